// File: rtl/cnn_pkg.sv
// Shared constants, width helpers and FSM encodings for the CNN kernel family.
// Default geometry lives here so the interface, bench and top agree on widths.
package cnn_pkg;
    localparam int P_KX     = 5;
    localparam int P_KY     = 5;
    localparam int P_CH     = 3;
    localparam int P_I_F_BW = 8;
    localparam int P_W_BW   = 8;
    localparam int P_B_BW   = 16;
    localparam int P_O_F_BW = 8;
    localparam int P_SH_BW  = 5;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // One bit of headroom on top of the widest of channel sum and bias.
    function automatic int acc_bw(input int kx, ky, ch, ifbw, wbw, bbw);
        int a;
        a = ifbw + wbw + clog2(kx * ky) + clog2(ch);
        return ((a > bbw) ? a : bbw) + 1;
    endfunction

    localparam int M_BW   = P_I_F_BW + P_W_BW;
    localparam int AK_BW  = M_BW + clog2(P_KX * P_KY);
    localparam int ACC_BW = acc_bw(P_KX, P_KY, P_CH, P_I_F_BW, P_W_BW, P_B_BW);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int ob);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (ob - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction
endpackage

// File: rtl/cnn_kernel_mc_if.sv
// Load / window / result bus of the multi-channel kernel.
interface cnn_kernel_mc_if
    import cnn_pkg::*;
#(
    parameter int KX = P_KX, KY = P_KY, CH = P_CH,
    parameter int I_F_BW = P_I_F_BW, W_BW = P_W_BW, B_BW = P_B_BW,
    parameter int O_F_BW = P_O_F_BW, SH_BW = P_SH_BW
);
    localparam int IF_ACC_BW = acc_bw(KX, KY, CH, I_F_BW, W_BW, B_BW);

    logic                        i_load_start;
    logic [B_BW-1:0]             i_bias;
    logic                        i_wgt_valid;
    logic [KX*KY*W_BW-1:0]       i_wgt_data;
    logic                        i_relu_en;
    logic [SH_BW-1:0]            i_shift;
    logic                        i_in_valid;
    logic [KX*KY*I_F_BW-1:0]     i_in_fmap;
    logic                        o_in_ready;
    logic                        o_ot_valid;
    logic [O_F_BW-1:0]           o_ot_data;
    logic [IF_ACC_BW-1:0]        o_ot_acc;
    logic                        o_load_done;

    modport master (
        output i_load_start, i_bias, i_wgt_valid, i_wgt_data, i_relu_en, i_shift,
               i_in_valid, i_in_fmap,
        input  o_in_ready, o_ot_valid, o_ot_data, o_ot_acc, o_load_done
    );
    modport slave (
        input  i_load_start, i_bias, i_wgt_valid, i_wgt_data, i_relu_en, i_shift,
               i_in_valid, i_in_fmap,
        output o_in_ready, o_ot_valid, o_ot_data, o_ot_acc, o_load_done
    );
endinterface

// File: rtl/cnn_mac_tree.sv
// Stages 1-2: per-element products, then the registered window sum.
// Valid and tag bits ride alongside; flush drops whatever is in flight.
module cnn_mac_tree
    import cnn_pkg::*;
#(
    parameter  int N      = 25,
    parameter  int I_F_BW = 8,
    parameter  int W_BW   = 8,
    parameter  int TAG_W  = 2,
    localparam int PROD_W = I_F_BW + W_BW,
    localparam int SUM_W  = PROD_W + clog2(N)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    in_vld,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic [N*I_F_BW-1:0]     in_fmap,
    input  logic [N*W_BW-1:0]       in_wgt,
    output logic                    out_vld,
    output logic [TAG_W-1:0]        out_tag,
    output logic signed [SUM_W-1:0] out_sum
);
    logic signed [PROD_W-1:0] prod_d [N];
    logic signed [PROD_W-1:0] prod_q [N];
    logic signed [SUM_W-1:0]  sum_d, sum_q;
    logic                     s1_vld_d, s1_vld_q, s2_vld_d, s2_vld_q;
    logic [TAG_W-1:0]         s1_tag_d, s1_tag_q, s2_tag_d, s2_tag_q;

    always_comb begin
        for (int e = 0; e < N; e++)
            prod_d[e] = PROD_W'($signed(in_fmap[e*I_F_BW +: I_F_BW]))
                      * PROD_W'($signed(in_wgt[e*W_BW +: W_BW]));
        sum_d = '0;
        for (int e = 0; e < N; e++)
            sum_d = sum_d + SUM_W'(prod_q[e]);
        s1_vld_d = in_vld & ~flush;
        s1_tag_d = flush ? '0 : in_tag;
        s2_vld_d = s1_vld_q & ~flush;
        s2_tag_d = flush ? '0 : s1_tag_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < N; e++) prod_q[e] <= '0;
            sum_q    <= '0;
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s1_tag_q <= '0;
            s2_tag_q <= '0;
        end else begin
            for (int e = 0; e < N; e++) prod_q[e] <= prod_d[e];
            sum_q    <= sum_d;
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            s1_tag_q <= s1_tag_d;
            s2_tag_q <= s2_tag_d;
        end
    end

    assign out_vld = s2_vld_q;
    assign out_tag = s2_tag_q;
    assign out_sum = sum_q;
endmodule

// File: rtl/cnn_kernel_mc.sv
// Multi-channel convolution kernel: weight bank + load FSM, channel-serial
// accumulation over CH windows, then bias / ReLU / shift / saturate.
module cnn_kernel_mc
    import cnn_pkg::*;
#(
    parameter int KX = P_KX, KY = P_KY, CH = P_CH,
    parameter int I_F_BW = P_I_F_BW, W_BW = P_W_BW, B_BW = P_B_BW,
    parameter int O_F_BW = P_O_F_BW, SH_BW = P_SH_BW
) (
    input logic           clk,
    input logic           reset_n,
    cnn_kernel_mc_if.slave bus
);
    localparam int N     = KX * KY;
    localparam int SUM_W = I_F_BW + W_BW + clog2(N);
    localparam int ACC_W = acc_bw(KX, KY, CH, I_F_BW, W_BW, B_BW);
    localparam int CW    = (CH > 1) ? clog2(CH) : 1;

    logic [1:0]                     state_d, state_q;
    logic [CW-1:0]                  wcnt_d, wcnt_q, ccnt_d, ccnt_q;
    logic signed [B_BW-1:0]         bias_d, bias_q;
    logic [CH-1:0][N*W_BW-1:0]      bank_d, bank_q;
    logic                           load_done_d, load_done_q;
    logic                           s3_vld_d, s3_vld_q, s3_last_d, s3_last_q;
    logic signed [ACC_W-1:0]        acc_d, acc_q;
    logic                           ot_valid_d, ot_valid_q;
    logic signed [O_F_BW-1:0]       ot_data_d, ot_data_q;
    logic signed [ACC_W-1:0]        ot_acc_d, ot_acc_q;
    logic signed [ACC_W-1:0]        acc_b, relu_v, sh_v;
    logic                           in_ready, accept, flush, fire;
    logic                           mt_vld;
    logic [1:0]                     mt_tag;
    logic signed [SUM_W-1:0]        mt_sum;
    logic [SH_BW-1:0]               shift;

    assign flush    = bus.i_load_start;
    assign in_ready = (state_q == ST_RUN);
    assign accept   = bus.i_in_valid & in_ready;
    assign shift    = bus.i_shift;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        bias_d      = bias_q;
        bank_d      = bank_q;
        load_done_d = 1'b0;
        if (bus.i_load_start) begin
            state_d = ST_LOAD;
            wcnt_d  = '0;
            bias_d  = bus.i_bias;
        end else if (state_q == ST_LOAD && bus.i_wgt_valid) begin
            bank_d[wcnt_q] = bus.i_wgt_data;
            if (wcnt_q == CW'(CH - 1)) begin
                state_d     = ST_RUN;
                wcnt_d      = '0;
                load_done_d = 1'b1;
            end else begin
                wcnt_d = wcnt_q + CW'(1);
            end
        end
        ccnt_d = ccnt_q;
        if (flush)       ccnt_d = '0;
        else if (accept) ccnt_d = (ccnt_q == CW'(CH - 1)) ? '0 : ccnt_q + CW'(1);
    end

    // Tag bit 1 = last channel of the group, bit 0 = first channel.
    cnn_mac_tree #(.N(N), .I_F_BW(I_F_BW), .W_BW(W_BW), .TAG_W(2)) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .in_vld  (accept),
        .in_tag  ({ccnt_q == CW'(CH - 1), ccnt_q == '0}),
        .in_fmap (bus.i_in_fmap),
        .in_wgt  (bank_q[ccnt_q]),
        .out_vld (mt_vld),
        .out_tag (mt_tag),
        .out_sum (mt_sum)
    );

    always_comb begin
        s3_vld_d  = mt_vld & ~flush;
        s3_last_d = flush ? 1'b0 : mt_tag[1];
        acc_d     = acc_q;
        if (mt_vld) acc_d = mt_tag[0] ? ACC_W'(mt_sum) : acc_q + ACC_W'(mt_sum);

        // A completed group still in stage 3 when a reload starts is dropped too.
        fire       = s3_vld_q & s3_last_q & ~flush;
        acc_b      = acc_q + ACC_W'(bias_q);
        relu_v     = (bus.i_relu_en && acc_b < 0) ? '0 : acc_b;
        sh_v       = relu_v >>> shift;
        ot_valid_d = fire;
        ot_acc_d   = fire ? acc_b : ot_acc_q;
        ot_data_d  = fire ? O_F_BW'(sat_signed(64'(sh_v), O_F_BW)) : ot_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            ccnt_q      <= '0;
            bias_q      <= '0;
            bank_q      <= '0;
            load_done_q <= 1'b0;
            s3_vld_q    <= 1'b0;
            s3_last_q   <= 1'b0;
            acc_q       <= '0;
            ot_valid_q  <= 1'b0;
            ot_data_q   <= '0;
            ot_acc_q    <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            ccnt_q      <= ccnt_d;
            bias_q      <= bias_d;
            bank_q      <= bank_d;
            load_done_q <= load_done_d;
            s3_vld_q    <= s3_vld_d;
            s3_last_q   <= s3_last_d;
            acc_q       <= acc_d;
            ot_valid_q  <= ot_valid_d;
            ot_data_q   <= ot_data_d;
            ot_acc_q    <= ot_acc_d;
        end
    end

    assign bus.o_in_ready  = in_ready;
    assign bus.o_ot_valid  = ot_valid_q;
    assign bus.o_ot_data   = ot_data_q;
    assign bus.o_ot_acc    = ot_acc_q;
    assign bus.o_load_done = load_done_q;
endmodule

// File: doc/cnn_kernel_mc.md
Name: cnn_kernel_mc

Overview:
Multi-channel successor to the single-window convolution kernel. It holds a weight bank of CH kernels, each KX×KY, plus one bias. It consumes one KX×KY input window per beat, channel-serially, and accumulates across all CH channels. After the last channel it adds the bias, applies optional ReLU, then an arithmetic right-shift, and saturates to O_F_BW. It sits between the line-buffer/window generator and the pooling stage.

Parameters:
KX, 5, kernel width
KY, 5, kernel height
CH, 3, input channels per output sample (≥1)
I_F_BW, 8, signed input feature width
W_BW, 8, signed weight width
B_BW, 16, signed bias width
O_F_BW, 8, signed output feature width
SH_BW, 5, width of requant shift amount

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_load_start  in  1  pulse: capture i_bias, enter LOAD
i_bias  in  B_BW  signed bias
i_wgt_valid  in  1  weight beat valid during LOAD
i_wgt_data  in  KX*KY*W_BW  one channel kernel, element e at [e*W_BW +: W_BW]
i_relu_en  in  1  ReLU enable, sampled with each stage-4 result
i_shift  in  SH_BW  right-shift amount, sampled with each stage-4 result
i_in_valid  in  1  window beat valid
i_in_fmap  in  KX*KY*I_F_BW  window, element e at [e*I_F_BW +: I_F_BW]
o_in_ready  out  1  high only in RUN
o_ot_valid  out  1  output sample valid, single-cycle
o_ot_data  out  O_F_BW  requantised, saturated result
o_ot_acc  out  ACC_BW  raw acc+bias before ReLU/shift (debug)
o_load_done  out  1  one-cycle pulse when LOAD completes

Behaviour:
- Widths: M_BW = I_F_BW+W_BW; AK_BW = M_BW+clog2(KX*KY); ACC_BW = max(AK_BW+clog2(CH), B_BW)+1. All arithmetic is signed with sign extension.
- FSM states:
  - IDLE (reset state): i_load_start → LOAD.
  - LOAD: the weight counter wcnt starts at 0. Each i_wgt_valid writes bank[wcnt] and increments wcnt. The write at wcnt=CH-1 → RUN, and o_load_done pulses the next cycle.
  - RUN: i_load_start → LOAD.
- i_load_start in any state, including LOAD, restarts LOAD with wcnt=0 and recaptures the bias.
- Beat acceptance: a beat is accepted when i_in_valid && o_in_ready. i_in_valid while not ready is ignored, with no side effects.
- Channel counter ccnt: 0..CH-1. Incremented per accepted beat, wraps to 0 after CH-1. It selects bank[ccnt] for the stage-1 multiply.
- Pipeline, accepted beat at cycle t:
  - Stage 1 (t+1): registered 25 products.
  - Stage 2 (t+2): registered kernel sum, AK_BW.
  - Stage 3 (t+3): channel accumulator. Loads the sum if the beat is first-of-group, otherwise adds it.
  - Stage 4 (t+4): acc+bias → ReLU (negative→0 when enabled) → arithmetic shift right by i_shift (truncation toward −inf) → saturate to [−2^(O_F_BW−1), 2^(O_F_BW−1)−1].
- Output timing: o_ot_valid is high at t+4 only for the beat with ccnt=CH-1. Latency is 4 cycles from the last-channel beat.
- Throughput: one beat per cycle, no bubbles. Back-to-back groups are allowed.
- Output hold: o_ot_data and o_ot_acc hold their value between valid pulses.
- On i_load_start:
  - stage 1–3 valid bits and first/last tags are cleared, so a partial group is discarded and emits no o_ot_valid;
  - ccnt is cleared;
  - a stage-4 result already registered still appears.
- CH=1: every beat produces an output.
- Reset mid-operation: all state returns to reset values on the next edge.
- Reset values: state IDLE, o_in_ready 0, o_ot_valid 0, o_ot_data 0, o_ot_acc 0, o_load_done 0, counters 0, bank 0, bias 0.

Decomposition:
- Shared package cnn_pkg: clog2 function, derived width constants (M_BW, AK_BW, ACC_BW), FSM state encodings (IDLE/LOAD/RUN), sat_signed function.
- Sub-module cnn_mac_tree: owns stages 1–2, the per-window multiply plus registered kernel sum, with valid/tag passthrough. It is reused later by the depthwise variant.
- Top-level owns the FSM, weight bank, counters, channel accumulator and requant stage.

Test Plan:
1. Defaults. Load CH=3 kernels of all +1, bias=0, shift=0, relu=0. Three beats of all +1 → single o_ot_valid 4 cycles after the third beat, o_ot_acc=75, o_ot_data=75.
2. Same setup, shift=2 → o_ot_data=18. Bias=−100 with relu=1 → o_ot_acc=−25, o_ot_data=0. Bias=−100 with relu=0 → o_ot_data=−25 (shift 0).
3. Saturation: weights all 127, fmap all 127, bias=0, shift=0 → o_ot_acc=1209675, o_ot_data=127. Weights −128, fmap 127 → o_ot_data=−128.
4. Six back-to-back beats, channel weights 1/2/3, fmap=1 → two o_ot_valid pulses three cycles apart, each o_ot_data=127 (sat) and o_ot_acc=150.
5. Two beats accepted, then i_load_start → no o_ot_valid, o_in_ready=0 during LOAD, i_in_valid ignored. After reload and three beats, output matches scenario 1.
6. Reset asserted at stage 3 of a group → all outputs 0, state IDLE. i_in_valid afterward ignored until a load completes; o_load_done pulses exactly once after the third weight beat.
